// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arb_pkg
// Brief    : State encoding, reset constants and grant decode for mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package arb_pkg;

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_OWN0 = 2'd1;
    localparam logic [1:0] ARB_OWN1 = 2'd2;

    // Master 1 is recorded as the previous owner so master 0 wins the first tie.
    localparam logic c_last_owner_rst = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = ARB_IDLE,
        ST_OWN0 = ARB_OWN0,
        ST_OWN1 = ARB_OWN1
    } arb_state_t;

    function automatic logic [1:0] arb_gnt(input arb_state_t st);
        logic [1:0] g;
        g = 2'b00;
        if (st == ST_OWN0) g = 2'b01;
        if (st == ST_OWN1) g = 2'b10;
        return g;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_if
// Brief    : Two-master / one-slave Wishbone-style bus bundle for mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0] m0_adr_i, m1_adr_i;
    logic [DW-1:0] m0_dat_i, m1_dat_i;
    logic          m0_wen_i, m1_wen_i;
    logic [3:0]    m0_sel_i, m1_sel_i;
    logic          m0_stb_i, m1_stb_i;
    logic          m0_cyc_i, m1_cyc_i;
    logic [DW-1:0] m0_dat_o, m1_dat_o;
    logic          m0_ack_o, m1_ack_o;
    logic          m0_err_o, m1_err_o;
    logic          m0_rty_o, m1_rty_o;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o;
    logic          s_wen_o;
    logic [3:0]    s_sel_o;
    logic          s_stb_o;
    logic          s_cyc_o;
    logic [DW-1:0] s_dat_i;
    logic          s_ack_i, s_err_i, s_rty_i;
    logic [1:0]    gnt_o;

    // Arbiter side: consumes master requests and slave responses.
    modport slave (
        input  m0_adr_i, m1_adr_i, m0_dat_i, m1_dat_i, m0_wen_i, m1_wen_i,
        input  m0_sel_i, m1_sel_i, m0_stb_i, m1_stb_i, m0_cyc_i, m1_cyc_i,
        input  s_dat_i, s_ack_i, s_err_i, s_rty_i,
        output m0_dat_o, m1_dat_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o,
        output m0_rty_o, m1_rty_o, s_adr_o, s_dat_o, s_wen_o, s_sel_o,
        output s_stb_o, s_cyc_o, gnt_o
    );

    // Environment side: the two masters plus the memory slave.
    modport master (
        output m0_adr_i, m1_adr_i, m0_dat_i, m1_dat_i, m0_wen_i, m1_wen_i,
        output m0_sel_i, m1_sel_i, m0_stb_i, m1_stb_i, m0_cyc_i, m1_cyc_i,
        output s_dat_i, s_ack_i, s_err_i, s_rty_i,
        input  m0_dat_o, m1_dat_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o,
        input  m0_rty_o, m1_rty_o, s_adr_o, s_dat_o, s_wen_o, s_sel_o,
        input  s_stb_o, s_cyc_o, gnt_o
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter_timer.sv
`default_nettype none
// ============================================================================
// Module   : arb_timer
// Brief    : Wait-state counter; o_expire is high while the count equals LIMIT.
// Revision : 1.0 - initial release
// ============================================================================
module arb_timer #(
    parameter int LIMIT = 255
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_clear,
    input  wire logic i_enable,
    output logic      o_expire
);
    localparam int c_CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

    logic [c_CW-1:0] r_count;

    assign o_expire = (r_count == c_CW'(LIMIT));

    // Holds at LIMIT once reached; the owner is released at that edge anyway.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expire) begin
            r_count <= r_count + c_CW'(1);
        end
    end
endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Round-robin arbiter sharing one Wishbone-style slave between two
//            masters; define ARB_TIMEOUT_EN to add the wait-state watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  wire logic    clk,
    input  wire logic    reset,
    mem_arbiter_if.slave bus
);
    arb_state_t r_state, w_next_state;
    logic       r_last_owner, w_next_last_owner;
    logic       w_own0, w_own1;
    logic       w_owner_stb;
    logic       w_expire;

    if (TIMEOUT < 1) begin : g_timeout_range_check
        $error("mem_arbiter: TIMEOUT must be at least 1");
    end

    assign w_own0      = (r_state == ST_OWN0);
    assign w_own1      = (r_state == ST_OWN1);
    assign w_owner_stb = (w_own0 && bus.m0_stb_i && bus.m0_cyc_i) ||
                         (w_own1 && bus.m1_stb_i && bus.m1_cyc_i);

`ifdef ARB_TIMEOUT_EN
    arb_timer #(
        .LIMIT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .i_clear  ((r_state == ST_IDLE) || bus.s_ack_i || bus.s_err_i || bus.s_rty_i),
        .i_enable (w_owner_stb),
        .o_expire (w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_last_owner <= c_last_owner_rst;
        end else begin
            r_state      <= w_next_state;
            r_last_owner <= w_next_last_owner;
        end
    end

    always_comb begin
        w_next_state      = r_state;
        w_next_last_owner = r_last_owner;
        case (r_state)
            ST_IDLE: begin
                if (bus.m0_cyc_i && bus.m1_cyc_i) begin
                    w_next_state = r_last_owner ? ST_OWN0 : ST_OWN1;
                end else if (bus.m0_cyc_i) begin
                    w_next_state = ST_OWN0;
                end else if (bus.m1_cyc_i) begin
                    w_next_state = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (!bus.m0_cyc_i || w_expire) begin
                    w_next_state      = ST_IDLE;
                    w_next_last_owner = 1'b0;
                end
            end
            ST_OWN1: begin
                if (!bus.m1_cyc_i || w_expire) begin
                    w_next_state      = ST_IDLE;
                    w_next_last_owner = 1'b1;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign bus.gnt_o    = arb_gnt(r_state);
    assign bus.m0_dat_o = bus.s_dat_i;
    assign bus.m1_dat_o = bus.s_dat_i;

    // In the expiry cycle the slave is dropped and the owner sees only err.
    always_comb begin
        bus.s_adr_o  = bus.m0_adr_i;
        bus.s_dat_o  = bus.m0_dat_i;
        bus.s_sel_o  = bus.m0_sel_i;
        bus.s_wen_o  = 1'b0;
        bus.s_stb_o  = 1'b0;
        bus.s_cyc_o  = 1'b0;
        bus.m0_ack_o = 1'b0;
        bus.m0_err_o = 1'b0;
        bus.m0_rty_o = 1'b0;
        bus.m1_ack_o = 1'b0;
        bus.m1_err_o = 1'b0;
        bus.m1_rty_o = 1'b0;
        if (w_own0) begin
            bus.s_wen_o  = bus.m0_wen_i;
            bus.s_stb_o  = w_owner_stb && !w_expire;
            bus.s_cyc_o  = bus.m0_cyc_i && !w_expire;
            bus.m0_ack_o = bus.s_ack_i && !w_expire;
            bus.m0_err_o = bus.s_err_i || w_expire;
            bus.m0_rty_o = bus.s_rty_i && !w_expire;
        end
        if (w_own1) begin
            bus.s_adr_o  = bus.m1_adr_i;
            bus.s_dat_o  = bus.m1_dat_i;
            bus.s_sel_o  = bus.m1_sel_i;
            bus.s_wen_o  = bus.m1_wen_i;
            bus.s_stb_o  = w_owner_stb && !w_expire;
            bus.s_cyc_o  = bus.m1_cyc_i && !w_expire;
            bus.m1_ack_o = bus.s_ack_i && !w_expire;
            bus.m1_err_o = bus.s_err_i || w_expire;
            bus.m1_rty_o = bus.s_rty_i && !w_expire;
        end
    end
endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master, one-slave arbiter for the core's 32-bit Wishbone-style memory port (adr/dat/wen/sel/stb/cyc/ack/err/rty).
- Lets the CPU core (master 0) and a secondary requester (master 1, e.g. loader/debug/DMA) share one memory slave.
- Grant is registered and held for a whole bus cycle (while the owner's cyc is high). Ties resolve round-robin.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 255, max cycles the owner's stb may wait without ack/err/rty; only used with ARB_TIMEOUT_EN.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- m0_adr_i, m1_adr_i  input  AW  master addresses.
- m0_dat_i, m1_dat_i  input  DW  master write data.
- m0_wen_i, m1_wen_i  input  1  master write enables.
- m0_sel_i, m1_sel_i  input  4  master byte selects.
- m0_stb_i, m1_stb_i  input  1  master strobes.
- m0_cyc_i, m1_cyc_i  input  1  master cycle requests.
- m0_dat_o, m1_dat_o  output  DW  read data; slave data routed to both, qualified by ack.
- m0_ack_o, m1_ack_o  output  1  acknowledge, owner only.
- m0_err_o, m1_err_o  output  1  error, owner only.
- m0_rty_o, m1_rty_o  output  1  retry, owner only.
- s_adr_o  output  AW  slave address.
- s_dat_o  output  DW  slave write data.
- s_wen_o  output  1  slave write enable.
- s_sel_o  output  4  slave byte select.
- s_stb_o  output  1  slave strobe.
- s_cyc_o  output  1  slave cycle.
- s_dat_i  input  DW  slave read data.
- s_ack_i, s_err_i, s_rty_i  input  1  slave responses.
- gnt_o  output  2  one-hot current grant; 00 = idle.

Behaviour:
- States: IDLE, OWN0, OWN1. Register last_owner records the master that most recently owned the bus.
- Reset: state=IDLE, gnt_o=00, last_owner=1 (so master 0 wins the first tie). All s_* control outputs and all m*_ack/err/rty are 0.
- IDLE:
  - Only m0_cyc_i high -> OWN0.
  - Only m1_cyc_i high -> OWN1.
  - Both high -> grant the master that is not last_owner.
  - Neither high -> stay in IDLE.
- OWNn: stay while mn_cyc_i is high. When mn_cyc_i is low at a clock edge -> IDLE, and last_owner<=n.
  - At least one IDLE cycle always separates ownerships; no back-to-back handover.
- Muxing (combinational from registered state):
  - In OWNn, s_* outputs follow master n's inputs, and s_ack/err/rty route to mn_* only.
  - The non-owner's ack/err/rty are forced to 0.
  - In IDLE, s_stb_o=s_cyc_o=s_wen_o=0; s_adr_o/s_dat_o/s_sel_o follow master 0 (don't-care).
- Latency:
  - Request in IDLE -> grant visible the next cycle.
  - The first slave stb is one cycle after cyc rises; masters must hold stb until a response arrives.
- A master dropping cyc in the same cycle as a slave ack: the ack is still routed to it and the release happens at that edge.
- Slave response while IDLE: discarded, not forwarded.
- reset mid-cycle: immediate return to the reset values; the in-flight transfer is abandoned and the slave sees stb/cyc low the next cycle.
- mn_cyc_i low with mn_stb_i high is treated as no request.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - Counter clears when entering OWNn and on any s_ack_i/s_err_i/s_rty_i; otherwise increments each OWNn cycle while s_stb_o is high.
  - When the count equals TIMEOUT, the arbiter drives mn_err_o=1 for exactly one cycle, forces s_stb_o=s_cyc_o=0 in that cycle, and the next state is IDLE.
  - A late slave response arriving after the timeout is discarded.
- Undefined: no counter is built; the owner may wait forever.

Decomposition:
- Package arb_pkg: state encoding constants (ARB_IDLE=2'd0, ARB_OWN0=2'd1, ARB_OWN1=2'd2) and the reset value of last_owner.
- One sub-module, arb_timer: counter with clear/enable/expire, instantiated only under ARB_TIMEOUT_EN.

Test Plan:
- Reset then m0 read at adr 0x1000, slave acks after 2 cycles with 0xDEADBEEF -> gnt_o=01 one cycle after cyc; s_adr_o=0x1000; m0_ack_o pulse with m0_dat_o=0xDEADBEEF; m1_ack_o stays 0.
- m0 and m1 both raise cyc in the same cycle after reset -> m0 granted first; after m0 drops cyc, one IDLE cycle, then gnt_o=10.
- Repeated simultaneous requests over 4 transfers -> grants alternate 0,1,0,1.
- m1 write 0x55AA55AA to 0x20 with wen=1, sel=0xF while m0 idle -> slave sees wen=1 and matching data; m0_err/ack remain 0.
- reset asserted while OWN1 with stb high -> next cycle gnt_o=00 and s_cyc_o=0.
- With ARB_TIMEOUT_EN and TIMEOUT=4, slave never acks -> m0_err_o pulses one cycle after 4 cycles of stb; state returns to IDLE; a late s_ack_i is not forwarded.
